// File: rtl/dma_engine.sv
// dma_engine: moves one word between a dcache slot and DRAM per instruction.
// Store: dcache read (CACHE_RD/CACHE_WAIT) then DRAM write (DRAM_WR).
// Load:  DRAM read (DRAM_RD) then dcache write (CACHE_WR).
// Handshake: an instruction transfers on the rising edge where cmd_valid and
// cmd_ready are both 1; mem_req is held with stable fields until mem_ack=1.
// Cache-side states respect freeze; DRAM-side states do not, because DRAM
// is outside the frozen pipeline and its ack cannot be stalled.
module dma_engine #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mem_we,
    input  logic [1:0]        cmd_slot,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              dc_rd_valid,
    output logic              dc_rd_we,
    output logic [1:0]        dc_rd_slot,
    input  logic [DATA_W-1:0] dc_rd_dat,
    output logic              dc_wr_valid,
    output logic              dc_wr_we,
    output logic [1:0]        dc_wr_slot,
    output logic [DATA_W-1:0] dc_wr_dat,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CACHE_RD   = 3'd1,
        CACHE_WAIT = 3'd2,
        DRAM_WR    = 3'd3,
        DRAM_RD    = 3'd4,
        CACHE_WR   = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_slot;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                w_accept;

    assign w_accept  = cmd_valid & cmd_ready;
    assign dbg_state = r_state;

    // State register plus latched instruction fields and the captured data word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_slot  <= 2'd0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_slot <= cmd_slot;
                r_addr <= cmd_addr;
            end
            // dcache data arrives one cycle after the read instruction.
            if (r_state == CACHE_WAIT && !freeze) begin
                r_data <= dc_rd_dat;
            end
            if (r_state == DRAM_RD && mem_ack) begin
                r_data <= mem_rdata;
            end
        end
    end

    // Next-state decode; cache-side states stall under freeze.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_accept) w_next = cmd_mem_we ? CACHE_RD : DRAM_RD;
            CACHE_RD:   if (!freeze)  w_next = CACHE_WAIT;
            CACHE_WAIT: if (!freeze)  w_next = DRAM_WR;
            DRAM_WR:    if (mem_ack)  w_next = DONE;
            DRAM_RD:    if (mem_ack)  w_next = CACHE_WR;
            CACHE_WR:   if (!freeze)  w_next = DONE;
            DONE:       if (!freeze)  w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // Moore outputs decoded from state; every field is zero outside its state.
    always_comb begin
        cmd_ready   = 1'b0;
        dc_rd_valid = 1'b0;
        dc_rd_we    = 1'b0;
        dc_rd_slot  = 2'd0;
        dc_wr_valid = 1'b0;
        dc_wr_we    = 1'b0;
        dc_wr_slot  = 2'd0;
        dc_wr_dat   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        done        = 1'b0;
        case (r_state)
            IDLE: cmd_ready = !freeze;
            CACHE_RD: begin
                dc_rd_valid = 1'b1;
                dc_rd_we    = 1'b1;
                dc_rd_slot  = r_slot;
            end
            DRAM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_data;
            end
            DRAM_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
            end
            CACHE_WR: begin
                dc_wr_valid = 1'b1;
                dc_wr_slot  = r_slot;
                dc_wr_dat   = r_data;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed scenarios for dma_engine with hand-computed values.
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge.
module tb_dma_engine;

    localparam int DW = 18;
    localparam int AW = 20;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          freeze = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_mem_we = 1'b0;
    logic [1:0]    cmd_slot = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic          dc_rd_valid, dc_rd_we;
    logic [1:0]    dc_rd_slot;
    logic [DW-1:0] dc_rd_dat = '0;
    logic          dc_wr_valid, dc_wr_we;
    logic [1:0]    dc_wr_slot;
    logic [DW-1:0] dc_wr_dat;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          done;
    logic [2:0]    dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    dma_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mem_we(cmd_mem_we),
        .cmd_slot(cmd_slot), .cmd_addr(cmd_addr),
        .dc_rd_valid(dc_rd_valid), .dc_rd_we(dc_rd_we), .dc_rd_slot(dc_rd_slot),
        .dc_rd_dat(dc_rd_dat),
        .dc_wr_valid(dc_wr_valid), .dc_wr_we(dc_wr_we), .dc_wr_slot(dc_wr_slot),
        .dc_wr_dat(dc_wr_dat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .dbg_state(dbg_state)
    );

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Store: offer command, dcache read (optionally frozen), DRAM write, done.
    task automatic run_store(input logic [1:0] slot, input logic [AW-1:0] addr,
                             input logic [DW-1:0] word, input int ack_delay,
                             input int frz, input bit hold);
        logic [DW-1:0] exp_w;
        cmd_valid = 1'b1; cmd_mem_we = 1'b1; cmd_slot = slot; cmd_addr = addr;
        dc_rd_dat = '0; mem_ack = 1'b0; freeze = 1'b0;
        exp_q.push_back(word);
        mid();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL st_ready: got %0b want 1", cmd_ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL st_idle_done: got %0b want 0", done); end
        next_cycle();
        // CACHE_RD; change command fields and drive a stray ack to prove they are ignored
        if (!hold) cmd_valid = 1'b0;
        cmd_addr = ~addr; cmd_slot = ~slot; mem_ack = 1'b1; dc_rd_dat = ~word;
        for (int i = 0; i <= frz; i++) begin
            freeze = (i < frz);
            mid();
            n_cmp++; if (dbg_state !== 3'd1) begin n_bad++; $display("FAIL st_rd_state[%0d]: got %0d want 1", i, dbg_state); end
            n_cmp++; if ({dc_rd_valid, dc_rd_we, dc_rd_slot} !== {1'b1, 1'b1, slot}) begin n_bad++; $display("FAIL st_rd_port[%0d]: got %b want %b", i, {dc_rd_valid, dc_rd_we, dc_rd_slot}, {2'b11, slot}); end
            n_cmp++; if ({cmd_ready, mem_req, dc_wr_valid} !== 3'b000) begin n_bad++; $display("FAIL st_rd_quiet[%0d]: got %b want 000", i, {cmd_ready, mem_req, dc_wr_valid}); end
            next_cycle();
        end
        freeze = 1'b0;
        // CACHE_WAIT: the word the dcache returns this cycle must be captured
        dc_rd_dat = word;
        mid();
        n_cmp++; if (dbg_state !== 3'd2) begin n_bad++; $display("FAIL st_wait_state: got %0d want 2", dbg_state); end
        n_cmp++; if ({dc_rd_valid, mem_req} !== 2'b00) begin n_bad++; $display("FAIL st_wait_quiet: got %b want 00", {dc_rd_valid, mem_req}); end
        next_cycle();
        // DRAM_WR
        dc_rd_dat = ~word;
        for (int i = 0; i <= ack_delay; i++) begin
            mem_ack = (i == ack_delay);
            mid();
            n_cmp++; if ({mem_req, mem_we, done, dc_rd_valid, dc_wr_valid} !== 5'b11000) begin n_bad++; $display("FAIL st_dram_ctl[%0d]: got %b want 11000", i, {mem_req, mem_we, done, dc_rd_valid, dc_wr_valid}); end
            n_cmp++; if (mem_addr !== addr) begin n_bad++; $display("FAIL st_dram_addr[%0d]: got %h want %h", i, mem_addr, addr); end
            if (i == ack_delay) begin
                exp_w = exp_q.pop_front();
                n_cmp++; if (mem_wdata !== exp_w) begin n_bad++; $display("FAIL st_dram_wdata: got %h want %h", mem_wdata, exp_w); end
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        // DONE
        mid();
        n_cmp++; if ({done, mem_req, cmd_ready} !== 3'b100) begin n_bad++; $display("FAIL st_done: got %b want 100", {done, mem_req, cmd_ready}); end
        next_cycle();
    endtask

    // Load: offer command, DRAM read (optionally ack under freeze), dcache write, done.
    task automatic run_load(input logic [1:0] slot, input logic [AW-1:0] addr,
                            input logic [DW-1:0] rdata, input int ack_delay,
                            input int frz, input bit hold);
        logic [DW-1:0] exp_w;
        cmd_valid = 1'b1; cmd_mem_we = 1'b0; cmd_slot = slot; cmd_addr = addr;
        mem_ack = 1'b0; freeze = 1'b0;
        exp_q.push_back(rdata);
        mid();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready: got %0b want 1", cmd_ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ld_idle_done: got %0b want 0", done); end
        next_cycle();
        // DRAM_RD
        if (!hold) cmd_valid = 1'b0;
        cmd_addr = ~addr; cmd_slot = ~slot; cmd_mem_we = 1'b1;
        for (int i = 0; i <= ack_delay; i++) begin
            mem_ack   = (i == ack_delay);
            mem_rdata = (i == ack_delay) ? rdata : ~rdata;
            freeze    = (frz > 0) && (i == ack_delay);
            mid();
            n_cmp++; if (dbg_state !== 3'd4) begin n_bad++; $display("FAIL ld_dram_state[%0d]: got %0d want 4", i, dbg_state); end
            n_cmp++; if ({mem_req, mem_we, dc_rd_valid, dc_wr_valid} !== 4'b1000) begin n_bad++; $display("FAIL ld_dram_ctl[%0d]: got %b want 1000", i, {mem_req, mem_we, dc_rd_valid, dc_wr_valid}); end
            n_cmp++; if (mem_addr !== addr) begin n_bad++; $display("FAIL ld_dram_addr[%0d]: got %h want %h", i, mem_addr, addr); end
            next_cycle();
        end
        mem_ack = 1'b0; mem_rdata = ~rdata;
        exp_w = exp_q.pop_front();
        // CACHE_WR: held while frozen, then exactly one unfrozen cycle
        for (int j = 0; j <= frz; j++) begin
            freeze = (j < frz);
            mid();
            n_cmp++; if ({dc_wr_valid, dc_wr_we, dc_wr_slot} !== {1'b1, 1'b0, slot}) begin n_bad++; $display("FAIL ld_wr_port[%0d]: got %b want %b", j, {dc_wr_valid, dc_wr_we, dc_wr_slot}, {2'b10, slot}); end
            n_cmp++; if (dc_wr_dat !== exp_w) begin n_bad++; $display("FAIL ld_wr_dat[%0d]: got %h want %h", j, dc_wr_dat, exp_w); end
            n_cmp++; if ({mem_req, done} !== 2'b00) begin n_bad++; $display("FAIL ld_wr_quiet[%0d]: got %b want 00", j, {mem_req, done}); end
            next_cycle();
        end
        freeze = 1'b0;
        // DONE
        mid();
        n_cmp++; if ({done, dc_wr_valid, mem_req} !== 3'b100) begin n_bad++; $display("FAIL ld_done: got %b want 100", {done, dc_wr_valid, mem_req}); end
        next_cycle();
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b0;
        next_cycle(); next_cycle();
        mid();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", cmd_ready); end
        n_cmp++; if ({done, mem_req, dc_rd_valid, dc_wr_valid, mem_we, dc_rd_we} !== 6'b0) begin n_bad++; $display("FAIL rst_ctl: got %b want 000000", {done, mem_req, dc_rd_valid, dc_wr_valid, mem_we, dc_rd_we}); end
        n_cmp++; if ({mem_addr, mem_wdata, dc_wr_dat} !== '0) begin n_bad++; $display("FAIL rst_data: got %h/%h/%h want 0", mem_addr, mem_wdata, dc_wr_dat); end
        n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        reset = 1'b1;
        next_cycle();
        mid();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %0b want 1", cmd_ready); end
        next_cycle();
    endtask

    task automatic test_freeze_idle();
        freeze = 1'b1; cmd_valid = 1'b1; cmd_mem_we = 1'b1; cmd_slot = 2'd2; cmd_addr = 20'h00055;
        mid();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL frz_idle_ready: got %0b want 0", cmd_ready); end
        next_cycle();
        mid();
        n_cmp++; if ({dbg_state, dc_rd_valid} !== 4'b0000) begin n_bad++; $display("FAIL frz_idle_hold: got %b want 0000", {dbg_state, dc_rd_valid}); end
        cmd_valid = 1'b0; freeze = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_dram();
        cmd_valid = 1'b1; cmd_mem_we = 1'b1; cmd_slot = 2'd2; cmd_addr = 20'h00777;
        dc_rd_dat = 18'h0AAAA;
        next_cycle();                 // accepted -> CACHE_RD
        cmd_valid = 1'b0;
        next_cycle(); next_cycle();   // CACHE_WAIT -> DRAM_WR
        mid();
        n_cmp++; if ({mem_req, dbg_state} !== 4'b1011) begin n_bad++; $display("FAIL rmd_in_dram: got %b want 1011", {mem_req, dbg_state}); end
        next_cycle();                 // still waiting for ack
        reset = 1'b0; mem_ack = 1'b1;
        mid();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmd_sync: got %0b want 1", mem_req); end
        next_cycle();
        mem_ack = 1'b0;
        mid();
        n_cmp++; if ({mem_req, done, dbg_state} !== 5'b00000) begin n_bad++; $display("FAIL rmd_abort: got %b want 00000", {mem_req, done, dbg_state}); end
        reset = 1'b1;
        next_cycle();
        mid();
        n_cmp++; if ({cmd_ready, done, mem_req} !== 3'b100) begin n_bad++; $display("FAIL rmd_release: got %b want 100", {cmd_ready, done, mem_req}); end
        next_cycle();
        mid();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmd_no_done: got %0b want 0", done); end
        next_cycle();
    endtask

    task automatic test_store();        run_store(2'd2, 20'h00010, 18'h2A5A5, 0, 0, 1'b0); endtask
    task automatic test_load();         run_load (2'd2, 20'h00ABC, 18'h1FFFF, 3, 0, 1'b0); endtask
    task automatic test_freeze_cache_rd(); run_store(2'd2, 20'h00010, 18'h2A5A5, 0, 5, 1'b0); endtask
    task automatic test_freeze_dram_rd();  run_load (2'd2, 20'h00123, 18'h0F0F0, 1, 3, 1'b0); endtask

    task automatic test_other_slot();
        run_store(2'd1, 20'hFFFFF, 18'h3FFFF, 2, 0, 1'b0);
        run_load (2'd0, 20'h55555, 18'h12345, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_store(2'd2, 20'h00200, 18'h15555, 0, 0, 1'b1);
        run_load (2'd2, 20'h00300, 18'h2AAAA, 1, 0, 1'b1);
        run_store(2'd3, 20'h00400, 18'h00001, 0, 0, 1'b0);
        cmd_valid = 1'b0;
    endtask

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_freeze_cache_rd();
        test_freeze_dram_rd();
        test_other_slot();
        test_freeze_idle();
        test_reset_mid_dram();
        test_back_to_back();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning width of one cache-slot word.
REQ-002 SHALL have parameter ADDR_W, default 20, meaning DRAM word-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous active-low reset; 0 = reset.
REQ-005 SHALL have port freeze  in  1  pipeline freeze shared with dcache.
REQ-006 SHALL have port cmd_valid  in  1  DMA instruction offered.
REQ-007 SHALL have port cmd_ready  out  1  engine accepts instruction this cycle.
REQ-008 SHALL have port cmd_mem_we  in  1  1 = cache-to-DRAM store; 0 = DRAM-to-cache load.
REQ-009 SHALL have port cmd_slot  in  2  dcache slot; 2'd2 = single-tile slot.
REQ-010 SHALL have port cmd_addr  in  ADDR_W  DRAM word address.
REQ-011 SHALL have port dc_rd_valid  out  1  stage-1 read-port instruction valid.
REQ-012 SHALL have port dc_rd_we  out  1  stage-1 mem_we field; driven to 1.
REQ-013 SHALL have port dc_rd_slot  out  2  stage-1 cache_slot field.
REQ-014 SHALL have port dc_rd_dat  in  DATA_W  stage-2 read data from dcache.
REQ-015 SHALL have port dc_wr_valid  out  1  stage-3 write-port instruction valid.
REQ-016 SHALL have port dc_wr_we  out  1  stage-3 mem_we field; driven to 0.
REQ-017 SHALL have port dc_wr_slot  out  2  stage-3 cache_slot field.
REQ-018 SHALL have port dc_wr_dat  out  DATA_W  stage-3 write data.
REQ-019 SHALL have port mem_req  out  1  DRAM request, held until acknowledged.
REQ-020 SHALL have port mem_we  out  1  DRAM write when 1.
REQ-021 SHALL have port mem_addr  out  ADDR_W  DRAM address.
REQ-022 SHALL have port mem_wdata  out  DATA_W  DRAM write data.
REQ-023 SHALL have port mem_ack  in  1  DRAM completes request this cycle.
REQ-024 SHALL have port mem_rdata  in  DATA_W  DRAM read data, valid when mem_ack=1.
REQ-025 SHALL have port done  out  1  one-cycle pulse at instruction completion.

Function
REQ-026 SHALL implement FSM states IDLE, CACHE_RD, CACHE_WAIT, DRAM_WR, DRAM_RD, CACHE_WR, DONE.
REQ-027 SHALL assert cmd_ready only in IDLE with freeze=0; acceptance at cmd_valid&cmd_ready latches mem_we, slot, addr.
REQ-028 SHALL move IDLE->CACHE_RD for store and IDLE->DRAM_RD for load on acceptance.
REQ-029 SHALL assert dc_rd_valid=1, dc_rd_we=1, dc_rd_slot=latched slot only while in CACHE_RD; CACHE_RD->CACHE_WAIT after one unfrozen cycle.
REQ-030 SHALL capture dc_rd_dat at end of the first unfrozen CACHE_WAIT cycle (dcache one-cycle read latency), then go to DRAM_WR.
REQ-031 SHALL in DRAM_WR drive mem_req=1, mem_we=1, mem_addr, mem_wdata=captured word, stable until mem_ack; on mem_ack go to DONE.
REQ-032 SHALL in DRAM_RD drive mem_req=1, mem_we=0, mem_addr; on mem_ack capture mem_rdata and go to CACHE_WR.
REQ-033 SHALL in CACHE_WR assert dc_wr_valid=1, dc_wr_we=0, dc_wr_slot, dc_wr_dat=captured word for exactly one unfrozen cycle, then go to DONE.
REQ-034 SHALL pulse done=1 for one cycle in DONE and return to IDLE next cycle.
REQ-035 SHALL, while freeze=1, hold state and all dc_* outputs unchanged in CACHE_RD, CACHE_WAIT, CACHE_WR, and DONE.
REQ-036 SHALL keep DRAM states unaffected by freeze: mem_ack under freeze still captures data and advances state.
REQ-037 SHALL ignore mem_ack outside DRAM_WR/DRAM_RD; mem_ack in the first DRAM cycle is legal (minimum one cycle of mem_req).
REQ-038 SHALL still complete the full sequence for a cmd_slot other than 2'd2; data content is then dcache-defined.
REQ-039 SHALL gate dc_rd_valid, dc_wr_valid, and mem_req to 0 in every state other than those named above.

Reset
REQ-040 SHALL, when reset=0 at a rising edge, enter IDLE and clear captured data, done, dc_rd_valid, dc_wr_valid, and mem_req; all outputs read 0 except cmd_ready.
REQ-041 SHALL abort any in-flight instruction on reset, including mid-DRAM handshake, without pulsing done; cmd_ready=1 on the first cycle after reset=1 if freeze=0.

Verification
REQ-042 Store, slot 2, addr 0x00010, dcache returns 0x2A5A5 -> dc_rd_valid one cycle; mem_wdata=0x2A5A5 at addr 0x00010; done 4 cycles after acceptance when mem_ack is immediate.
REQ-043 Load, addr 0x00ABC, mem_ack after 3 wait cycles with rdata 0x1FFFF -> dc_wr_valid one cycle, dc_wr_dat=0x1FFFF, slot 2, then done pulse.
REQ-044 freeze=1 for 5 cycles while in CACHE_RD -> dc_rd_* held 5 cycles; single capture; result identical to unfrozen run.
REQ-045 freeze=1 during DRAM_RD with mem_ack -> data captured; CACHE_WR waits until freeze=0 and then lasts one cycle.
REQ-046 reset=0 mid-DRAM_WR -> mem_req=0 next cycle, no done, cmd_ready=1 after release.
REQ-047 Back-to-back commands with cmd_valid held -> second accepted the cycle after done; no overlap of mem_req or dc_* valids.
